// File: rtl/des_core_arbiter.sv
// des_core_arbiter
// Round-robin front end that lets NUM_REQ job sources share a single
// des_encryption_unroll4 core. One job is in flight at a time: grant,
// capture, pulse start, wait for done (with watchdog), hand the result
// back tagged with the owning requester id.
//
// Handshake semantics (all valid/ready pairs in this block):
//   A transfer happens on a rising clk edge where valid and ready are both 1.
//   The source keeps valid and its data stable until that edge; ready may
//   depend combinationally on valid. req_* is the request channel into the
//   arbiter, resp_* is the result channel out of it.

module des_core_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int TIMEOUT = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ*64-1:0]   req_message,
    input  logic [NUM_REQ*768-1:0]  req_round_keys,
    output logic                    core_start,
    output logic [63:0]             core_message,
    output logic [767:0]            core_round_keys,
    input  logic                    core_done,
    input  logic [63:0]             core_result,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [ID_W-1:0]         resp_id,
    output logic [63:0]             resp_result,
    output logic                    busy,
    output logic                    timeout_err,
    output logic [1:0]              o_dbg_state
);

    // Timer only needs to reach TIMEOUT-1.
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [ID_W-1:0]    r_rr_ptr;
    logic [ID_W-1:0]    r_owner;
    logic [TW-1:0]      r_timer;
    logic               r_core_start;
    logic [63:0]        r_core_message;
    logic [767:0]       r_core_round_keys;
    logic               r_resp_valid;
    logic [ID_W-1:0]    r_resp_id;
    logic [63:0]        r_resp_result;
    logic               r_timeout_err;

    logic               w_found;
    logic [ID_W-1:0]    w_grant;
    logic [ID_W-1:0]    w_scan_idx;
    logic [NUM_REQ-1:0] w_req_ready;
    logic [ID_W-1:0]    w_owner_nxt;
    logic               w_wd_hit;
    logic               w_accept;
    logic               w_done_evt;
    logic               w_abort;
    logic               w_release;

    // Round-robin search: first valid requester starting at r_rr_ptr.
    always_comb begin
        w_found    = 1'b0;
        w_grant    = '0;
        w_scan_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_scan_idx = ID_W'((int'(r_rr_ptr) + k) % NUM_REQ);
            if (!w_found && req_valid[w_scan_idx]) begin
                w_found = 1'b1;
                w_grant = w_scan_idx;
            end
        end
    end

    // Ready is one-hot on the winner, and only while the FSM is idle.
    always_comb begin
        w_req_ready = '0;
        if (r_state == S_IDLE && w_found) begin
            w_req_ready[w_grant] = 1'b1;
        end
    end

    // Pointer for the next search: the slot just after the finished owner.
    always_comb begin
        w_owner_nxt = (r_owner == ID_W'(NUM_REQ - 1)) ? '0 : r_owner + ID_W'(1);
    end

    // Watchdog compare; a TIMEOUT of zero removes it entirely.
    generate
        if (TIMEOUT == 0) begin : g_no_wd
            assign w_wd_hit = 1'b0;
        end else begin : g_wd
            assign w_wd_hit = (r_timer == TW'(TIMEOUT - 1));
        end
    endgenerate

    // Next-state and event strobes; done takes priority over the watchdog.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_done_evt  = 1'b0;
        w_abort     = 1'b0;
        w_release   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (core_done) begin
                    w_done_evt  = 1'b1;
                    w_state_nxt = S_RESP;
                end else if (w_wd_hit) begin
                    w_abort     = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    w_release   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath: job capture, start pulse, timer, response and pointer update.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr          <= '0;
            r_owner           <= '0;
            r_timer           <= '0;
            r_core_start      <= 1'b0;
            r_core_message    <= '0;
            r_core_round_keys <= '0;
            r_resp_valid      <= 1'b0;
            r_resp_id         <= '0;
            r_resp_result     <= '0;
            r_timeout_err     <= 1'b0;
        end else begin
            // Start is high exactly in the ISSUE cycle that follows a grant.
            r_core_start  <= w_accept;
            r_timeout_err <= w_abort;

            if (w_accept) begin
                r_core_message    <= req_message[int'(w_grant) * 64 +: 64];
                r_core_round_keys <= req_round_keys[int'(w_grant) * 768 +: 768];
                r_owner           <= w_grant;
            end

            if (r_state == S_ISSUE) begin
                r_timer <= '0;
            end else if (r_state == S_WAIT) begin
                r_timer <= r_timer + TW'(1);
            end

            if (w_done_evt) begin
                r_resp_valid  <= 1'b1;
                r_resp_id     <= r_owner;
                r_resp_result <= core_result;
            end else if (w_release) begin
                r_resp_valid  <= 1'b0;
            end

            if (w_release || w_abort) begin
                r_rr_ptr <= w_owner_nxt;
            end
        end
    end

    assign req_ready       = w_req_ready;
    assign core_start      = r_core_start;
    assign core_message    = r_core_message;
    assign core_round_keys = r_core_round_keys;
    assign resp_valid      = r_resp_valid;
    assign resp_id         = r_resp_id;
    assign resp_result     = r_resp_result;
    assign timeout_err     = r_timeout_err;
    assign busy            = (r_state != S_IDLE);
    assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_des_core_arbiter.sv
// tb_des_core_arbiter
// Directed bench for des_core_arbiter: a grant table walked in a loop,
// followed by hand-written sequences for back-to-back jobs, response
// back-pressure, watchdog abort, reset in WAIT and a single busy requester.

module tb_des_core_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;
    localparam int TIMEOUT = 64;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [NUM_REQ-1:0]     req_valid      = '0;
    logic [NUM_REQ-1:0]     req_ready;
    logic [NUM_REQ*64-1:0]  req_message    = '0;
    logic [NUM_REQ*768-1:0] req_round_keys = '0;
    logic                   core_start;
    logic [63:0]            core_message;
    logic [767:0]           core_round_keys;
    logic                   core_done      = 1'b0;
    logic [63:0]            core_result    = '0;
    logic                   resp_valid;
    logic                   resp_ready     = 1'b1;
    logic [ID_W-1:0]        resp_id;
    logic [63:0]            resp_result;
    logic                   busy;
    logic                   timeout_err;
    logic [1:0]             o_dbg_state;

    des_core_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_message     (req_message),
        .req_round_keys  (req_round_keys),
        .core_start      (core_start),
        .core_message    (core_message),
        .core_round_keys (core_round_keys),
        .core_done       (core_done),
        .core_result     (core_result),
        .resp_valid      (resp_valid),
        .resp_ready      (resp_ready),
        .resp_id         (resp_id),
        .resp_result     (resp_result),
        .busy            (busy),
        .timeout_err     (timeout_err),
        .o_dbg_state     (o_dbg_state)
    );

    // ---------------- reference helpers ----------------
    // Key 133457799BBCDFF1: the one stored FIPS-46 vector; other plaintexts
    // get a fixed, message-dependent stand-in so results still track jobs.
    function automatic logic [63:0] des_model(input logic [63:0] m);
        if (m == 64'h0123_4567_89AB_CDEF) return 64'h85E8_1354_0F0A_B405;
        return m ^ 64'h5A5A_3C3C_0F0F_9696;
    endfunction

    function automatic logic [63:0] msg_of(input int tag, input int slot);
        return {16'(tag), 16'(slot), 32'h600D_F00D};
    endfunction

    function automatic logic [767:0] keys_of(input int slot);
        logic [767:0] k;
        k = '0;
        for (int j = 0; j < 12; j++) begin
            k[64*j +: 64] = {16'hC0DE, 16'(slot), 16'h5EED, 16'(j)};
        end
        return k;
    endfunction

    // ---------------- core model ----------------
    // Done is asserted L cycles after the cycle in which core_start is high.
    int          cm_lat   = 1;
    bit          cm_never = 1'b0;
    int          cm_cnt   = 0;
    bit          cm_busy  = 1'b0;
    logic [63:0] cm_msg   = '0;

    always @(posedge clk) begin
        #1;
        core_done   = 1'b0;
        core_result = 64'hDEAD_BEEF_DEAD_BEEF;
        if (core_start) begin
            cm_msg  = core_message;
            cm_cnt  = cm_lat;
            cm_busy = !cm_never;
        end else if (cm_busy) begin
            cm_cnt = cm_cnt - 1;
            if (cm_cnt == 0) begin
                core_done   = 1'b1;
                core_result = des_model(cm_msg);
                cm_busy     = 1'b0;
            end
        end
    end

    // ---------------- scoreboard ----------------
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [65:0] exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_keys(input string name, input logic [767:0] exp);
        n_checks++;
        if (core_round_keys !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, core_round_keys, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Advance one cycle; inputs are driven and outputs sampled 2ns after the edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_msgs(input int tag);
        for (int i = 0; i < NUM_REQ; i++) req_message[64*i +: 64] = msg_of(tag, i);
    endtask

    task automatic chk_reset_vals(input string p);
        chk({p, "_state"},  64'(o_dbg_state), 64'(ST_IDLE));
        chk({p, "_start"},  64'(core_start), 64'd0);
        chk({p, "_msg"},    core_message, 64'd0);
        chk_keys({p, "_keys"}, '0);
        chk({p, "_rvalid"}, 64'(resp_valid), 64'd0);
        chk({p, "_rid"},    64'(resp_id), 64'd0);
        chk({p, "_rres"},   resp_result, 64'd0);
        chk({p, "_toerr"},  64'(timeout_err), 64'd0);
        chk({p, "_busy"},   64'(busy), 64'd0);
        chk({p, "_ready"},  64'(req_ready), 64'd0);
    endtask

    // Runs one job whose grant happens in the current (IDLE) cycle.
    // Ends in the IDLE cycle after release, or in the first RESP cycle
    // when resp_ready is low.
    task automatic do_job(input logic [3:0] exp_ready, input int exp_id,
                          input int lat, input logic [3:0] clear);
        logic [63:0] m;
        logic [65:0] e;
        int          n;
        bit          extra;
        cm_lat   = lat;
        cm_never = 1'b0;
        #1;
        chk("grant_ready", 64'(req_ready), 64'(exp_ready));
        chk("idle_busy", 64'(busy), 64'd0);
        m = req_message[64*exp_id +: 64];
        exp_q.push_back({2'(exp_id), des_model(m)});
        tick();
        req_valid = req_valid & ~clear;
        chk("issue_start", 64'(core_start), 64'd1);
        chk("issue_state", 64'(o_dbg_state), 64'(ST_ISSUE));
        chk("issue_busy", 64'(busy), 64'd1);
        chk("issue_no_ready", 64'(req_ready), 64'd0);
        chk("issue_no_toerr", 64'(timeout_err), 64'd0);
        chk("issue_msg", core_message, m);
        chk_keys("issue_keys", keys_of(exp_id));
        n     = 0;
        extra = 1'b0;
        while (!resp_valid && n < 300) begin
            tick();
            n++;
            if (core_start) extra = 1'b1;
        end
        // core_start cycle s, done at s+L, resp_valid from s+L+1.
        chk("resp_latency", 64'(n), 64'(lat + 1));
        chk("single_start", 64'(extra), 64'd0);
        e = exp_q.pop_front();
        chk("resp_id", 64'(resp_id), 64'(e[65:64]));
        chk("resp_result", resp_result, e[63:0]);
        if (resp_ready) begin
            tick();
            chk("release_valid", 64'(resp_valid), 64'd0);
            chk("release_busy", 64'(busy), 64'd0);
            chk("release_state", 64'(o_dbg_state), 64'(ST_IDLE));
        end
    endtask

    // ---------------- stimulus table ----------------
    typedef struct {
        logic [3:0] valid;
        logic [3:0] exp_ready;
        int         exp_id;
        int         lat;
    } vec_t;

    vec_t vt[10];

    // ---------------- main test ----------------
    initial begin
        logic [63:0] hold_res;
        int          n;
        bit          saw_resp;

        // Pointer trace from reset: 0 ->3 ->0 ->1 ->1 ->3 ->1 ->0 ->2 ->0 ->2
        vt[0] = '{4'b0100, 4'b0100, 2, 17};
        vt[1] = '{4'b1111, 4'b1000, 3, 1};
        vt[2] = '{4'b1111, 4'b0001, 0, 2};
        vt[3] = '{4'b0001, 4'b0001, 0, 5};
        vt[4] = '{4'b0101, 4'b0100, 2, 3};
        vt[5] = '{4'b0011, 4'b0001, 0, 9};
        vt[6] = '{4'b1000, 4'b1000, 3, 1};
        vt[7] = '{4'b0110, 4'b0010, 1, 4};
        vt[8] = '{4'b1011, 4'b1000, 3, 2};
        vt[9] = '{4'b0010, 4'b0010, 1, 6};

        for (int i = 0; i < NUM_REQ; i++) req_round_keys[768*i +: 768] = keys_of(i);

        // Reset
        rst = 1'b1;
        tick();
        tick();
        chk_reset_vals("reset");
        rst = 1'b0;
        tick();

        // Grant table; vector 0 is the FIPS single-job case with L=17.
        for (int k = 0; k < 10; k++) begin
            set_msgs(k);
            if (k == 0) req_message[64*2 +: 64] = 64'h0123_4567_89AB_CDEF;
            req_valid = vt[k].valid;
            do_job(vt[k].exp_ready, vt[k].exp_id, vt[k].lat, vt[k].valid);
        end

        // All four valid continuously from a fresh pointer: order 0,1,2,3,0,1,2,3.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_msgs(50);
        req_valid = 4'hF;
        for (int j = 0; j < 8; j++) begin
            do_job(4'(1 << (j % 4)), j % 4, 1 + (j % 3) * 2, (j == 7) ? 4'hF : 4'h0);
            req_message[64*(j % 4) +: 64] = msg_of(60 + j, j % 4);
        end

        // Response back-pressure; slot 3 waits and is granted right after release.
        set_msgs(80);
        req_valid  = 4'b1010;
        resp_ready = 1'b0;
        do_job(4'b0010, 1, 4, 4'b0010);
        hold_res = des_model(msg_of(80, 1));
        for (int c = 0; c < 10; c++) begin
            tick();
            chk("hold_valid", 64'(resp_valid), 64'd1);
            chk("hold_id", 64'(resp_id), 64'd1);
            chk("hold_result", resp_result, hold_res);
            chk("hold_ready", 64'(req_ready), 64'd0);
            chk("hold_start", 64'(core_start), 64'd0);
            chk("hold_state", 64'(o_dbg_state), 64'(ST_RESP));
        end
        resp_ready = 1'b1;
        tick();
        chk("hold_release", 64'(resp_valid), 64'd0);
        do_job(4'b1000, 3, 2, 4'b1000);

        // Watchdog: owner 1 never completes; slots 0 and 2 then compete and
        // the pointer must land on 2. Start cycle s, 64 WAIT cycles, pulse at s+65.
        set_msgs(90);
        cm_never  = 1'b1;
        req_valid = 4'b0010;
        #1;
        chk("to_ready", 64'(req_ready), 64'b0010);
        tick();
        req_valid = 4'b0101;
        chk("to_start", 64'(core_start), 64'd1);
        n        = 0;
        saw_resp = 1'b0;
        while (!timeout_err && n < 150) begin
            tick();
            n++;
            if (resp_valid) saw_resp = 1'b1;
        end
        chk("to_cycles", 64'(n), 64'd65);
        chk("to_no_resp", 64'(saw_resp), 64'd0);
        chk("to_state", 64'(o_dbg_state), 64'(ST_IDLE));
        do_job(4'b0100, 2, 3, 4'b0101);

        // Reset while in WAIT; the core's done lands 3 cycles after the reset cycle.
        set_msgs(100);
        cm_lat    = 6;
        cm_never  = 1'b0;
        req_valid = 4'b0001;
        #1;
        chk("rw_ready", 64'(req_ready), 64'b0001);
        tick();
        req_valid = 4'b0000;
        tick();
        chk("rw_wait", 64'(o_dbg_state), 64'(ST_WAIT));
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_reset_vals("rw");
        for (int c = 0; c < 6; c++) begin
            tick();
            chk("rw_no_resp", 64'(resp_valid), 64'd0);
            chk("rw_idle", 64'(o_dbg_state), 64'(ST_IDLE));
            chk("rw_no_start", 64'(core_start), 64'd0);
        end
        // Pointer back at 0 after reset: slots 1 and 3 valid -> 1.
        set_msgs(110);
        req_valid = 4'b1010;
        do_job(4'b0010, 1, 2, 4'b1010);

        // Single requester holding valid: three grants, busy low one cycle between.
        set_msgs(120);
        req_valid = 4'b0010;
        for (int j = 0; j < 3; j++) begin
            do_job(4'b0010, 1, 3 + j, (j == 2) ? 4'b0010 : 4'b0000);
            req_message[64*1 +: 64] = msg_of(130 + j, 1);
        end
        tick();
        chk("final_idle", 64'(busy), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Absolute time limit in case a wait outside the bounded loops stalls.
    initial begin
        #300000;
        $display("FAIL global_timeout: got stall expected finish");
        $fatal(1, "time limit");
    end

endmodule
